// File: rtl/serial_rx.sv
// serial_rx: idle-high async-serial receiver (start, DATA_W bits LSB-first, stop) with a valid/ready output register.
// Define SERIAL_RX_PARITY_EN to expect an even-parity bit between the data bits and the stop bit.
module serial_rx #(
  parameter int DATA_W       = 8,
  parameter int CLKS_PER_BIT = 4
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              SIN,
  input  logic              READY,
  output logic [DATA_W-1:0] DOUT,
  output logic              VALID,
  output logic              BUSY,
  output logic              FRAME_ERR,
  output logic              OVERRUN
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int IW = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
  localparam logic [IW-1:0] IDX_LAST  = IW'(DATA_W - 1);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_START  = 3'd1;
  localparam logic [2:0] S_DATA   = 3'd2;
  localparam logic [2:0] S_STOP   = 3'd4;
`ifdef SERIAL_RX_PARITY_EN
  localparam logic [2:0] S_PARITY = 3'd3;
  localparam logic [2:0] S_AFTER_DATA = S_PARITY;
`else
  localparam logic [2:0] S_AFTER_DATA = S_STOP;
`endif

  logic [2:0]        state;
  logic [CW-1:0]     cnt;
  logic [IW-1:0]     idx;
  logic [DATA_W-1:0] word;
  logic              armed;
  logic              sin_m, sin_s;
  logic              stop_hit, frame_ok, frame_bad;
`ifdef SERIAL_RX_PARITY_EN
  logic              parity_bad;
`endif

  // SIN is asynchronous to CLK; resetting to 1 makes the line look idle
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      sin_m <= 1'b1;
      sin_s <= 1'b1;
    end else begin
      sin_m <= SIN;
      sin_s <= sin_m;
    end
  end

  assign stop_hit = (state == S_STOP) && (cnt == BIT_LAST);
`ifdef SERIAL_RX_PARITY_EN
  assign frame_ok = stop_hit && sin_s && !parity_bad;
`else
  assign frame_ok = stop_hit && sin_s;
`endif
  assign frame_bad = stop_hit && !frame_ok;
  assign BUSY      = (state != S_IDLE);

  // A line stuck low after a framing error must go high before another start is accepted
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state <= S_IDLE;
      cnt   <= '0;
      idx   <= '0;
      word  <= '0;
      armed <= 1'b0;
`ifdef SERIAL_RX_PARITY_EN
      parity_bad <= 1'b0;
`endif
    end else begin
      case (state)
        S_IDLE: begin
          cnt <= '0;
          if (sin_s) armed <= 1'b1;
          else if (armed) state <= S_START;
        end
        S_START: begin
          if (cnt == HALF_LAST) begin
            cnt   <= '0;
            idx   <= '0;
            state <= sin_s ? S_IDLE : S_DATA;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        S_DATA: begin
          if (cnt == BIT_LAST) begin
            cnt        <= '0;
            word[idx]  <= sin_s;
            idx        <= idx + 1'b1;
            if (idx == IDX_LAST) state <= S_AFTER_DATA;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
`ifdef SERIAL_RX_PARITY_EN
        S_PARITY: begin
          if (cnt == BIT_LAST) begin
            cnt        <= '0;
            parity_bad <= ^{word, sin_s};
            state      <= S_STOP;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
`endif
        S_STOP: begin
          if (cnt == BIT_LAST) begin
            cnt   <= '0;
            state <= S_IDLE;
            if (frame_bad) armed <= 1'b0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // A consumer taking the old word on the delivery edge frees the register for the new one
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      DOUT      <= '0;
      VALID     <= 1'b0;
      FRAME_ERR <= 1'b0;
      OVERRUN   <= 1'b0;
    end else begin
      FRAME_ERR <= frame_bad;
      OVERRUN   <= 1'b0;
      if (frame_ok) begin
        if (!VALID || READY) begin
          DOUT  <= word;
          VALID <= 1'b1;
        end else begin
          OVERRUN <= 1'b1;
        end
      end else if (VALID && READY) begin
        VALID <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_serial_rx.sv
// tb_serial_rx: self-checking bench for serial_rx driving whole frames and predicting results at frame level.
// Follows SERIAL_RX_PARITY_EN the same way the design does.
`timescale 1ns/1ps
module tb_serial_rx;

  localparam int DATA_W = 8;
  localparam int CPB    = 4;
`ifdef SERIAL_RX_PARITY_EN
  localparam int NBITS = DATA_W + 3;
  localparam int LAT   = 3 + CPB / 2 + (DATA_W + 2) * CPB;
`else
  localparam int NBITS = DATA_W + 2;
  localparam int LAT   = 3 + CPB / 2 + (DATA_W + 1) * CPB;
`endif

  logic CLK = 1'b0;
  logic RST = 1'b0;
  logic SIN = 1'b1;
  logic READY = 1'b0;
  logic [DATA_W-1:0] DOUT;
  logic VALID, BUSY, FRAME_ERR, OVERRUN;

  int assertCount = 0;
  int failCount = 0;
  int cyc = 0;
  int riseCycles[$];
  int errCycles[$];
  int ovrCycles[$];
  int busyRise[$];
  logic prevValid = 1'b0;
  logic prevBusy = 1'b0;
`ifdef SERIAL_RX_PARITY_EN
  logic flipParity = 1'b0;
`endif

  serial_rx #(.DATA_W(DATA_W), .CLKS_PER_BIT(CPB)) dut (
    .CLK(CLK), .RST(RST), .SIN(SIN), .READY(READY), .DOUT(DOUT),
    .VALID(VALID), .BUSY(BUSY), .FRAME_ERR(FRAME_ERR), .OVERRUN(OVERRUN)
  );

  always #5 CLK = ~CLK;

  // Event log, sampled just after each rising edge; cyc numbers the edges
  always @(posedge CLK) begin
    #1;
    cyc++;
    if (FRAME_ERR) errCycles.push_back(cyc);
    if (OVERRUN) ovrCycles.push_back(cyc);
    if (VALID && !prevValid) riseCycles.push_back(cyc);
    if (BUSY && !prevBusy) busyRise.push_back(cyc);
    prevValid = VALID;
    prevBusy = BUSY;
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic wait_to(input int target);
    while (cyc < target) @(negedge CLK);
  endtask

  task automatic clear_logs();
    riseCycles.delete();
    errCycles.delete();
    ovrCycles.delete();
    busyRise.delete();
  endtask

  task automatic drain();
    READY = 1'b1;
    repeat (2) @(negedge CLK);
    READY = 1'b0;
    clear_logs();
  endtask

  // Called at a negedge; returns at the negedge where the stop bit ends
  task automatic send_frame(input logic [DATA_W-1:0] data, input logic stopBit, output int startCyc);
    logic [NBITS-1:0] bits;
`ifdef SERIAL_RX_PARITY_EN
    bits = {stopBit, (^data) ^ flipParity, data, 1'b0};
`else
    bits = {stopBit, data, 1'b0};
`endif
    startCyc = cyc;
    for (int i = 0; i < NBITS; i++) begin
      SIN = bits[i];
      repeat (CPB) @(negedge CLK);
    end
  endtask

  task automatic test_reset();
    RST = 1'b0;
    SIN = 1'b1;
    READY = 1'b0;
    repeat (3) @(negedge CLK);
    assertCount++;
    if ({VALID, BUSY, FRAME_ERR, OVERRUN, DOUT} !== '0) begin
      failCount++;
      $display("[TB] FAIL reset_held: got %b expected all zero", {VALID, BUSY, FRAME_ERR, OVERRUN, DOUT});
    end
    RST = 1'b1;
    repeat (4) @(negedge CLK);
    assertCount++;
    if ({VALID, BUSY, FRAME_ERR, OVERRUN, DOUT} !== '0) begin
      failCount++;
      $display("[TB] FAIL reset_released_idle: got %b expected all zero", {VALID, BUSY, FRAME_ERR, OVERRUN, DOUT});
    end
  endtask

  task automatic test_single();
    int s;
    drain();
    READY = 1'b1;
    send_frame(8'hA5, 1'b1, s);
    wait_to(s + LAT - 1);
    assertCount++;
    if (VALID !== 1'b0 || BUSY !== 1'b1) begin
      failCount++;
      $display("[TB] FAIL single_before_delivery: VALID=%b BUSY=%b expected VALID=0 BUSY=1", VALID, BUSY);
    end
    wait_to(s + LAT);
    assertCount++;
    if (VALID !== 1'b1 || DOUT !== 8'hA5 || BUSY !== 1'b0) begin
      failCount++;
      $display("[TB] FAIL single_delivery: VALID=%b DOUT=%h BUSY=%b expected 1 a5 0", VALID, DOUT, BUSY);
    end
    assertCount++;
    if (busyRise.size() != 1 || busyRise[0] != s + 3) begin
      failCount++;
      $display("[TB] FAIL single_busy_start: %0d rises, first at %0d, expected one at %0d",
               busyRise.size(), (busyRise.size() > 0) ? busyRise[0] : -1, s + 3);
    end
    wait_to(s + LAT + 1);
    assertCount++;
    if (VALID !== 1'b0 || DOUT !== 8'hA5) begin
      failCount++;
      $display("[TB] FAIL single_consumed: VALID=%b DOUT=%h expected 0 a5", VALID, DOUT);
    end
  endtask

  task automatic test_back_to_back(input logic readySecond);
    int s1, s2;
    logic [DATA_W-1:0] expDout;
    drain();
    send_frame(8'h3C, 1'b1, s1);
    send_frame(8'hC3, 1'b1, s2);
    wait_to(s2 + LAT - 1);
    READY = readySecond;
    wait_to(s2 + LAT);
    READY = 1'b0;
    expDout = readySecond ? 8'hC3 : 8'h3C;
    assertCount++;
    if (riseCycles.size() != 1 || riseCycles[0] != s1 + LAT) begin
      failCount++;
      $display("[TB] FAIL b2b_first_rise: %0d rises, first at %0d, expected one at %0d",
               riseCycles.size(), (riseCycles.size() > 0) ? riseCycles[0] : -1, s1 + LAT);
    end
    assertCount++;
    if (VALID !== 1'b1 || DOUT !== expDout) begin
      failCount++;
      $display("[TB] FAIL b2b_word(ready=%b): VALID=%b DOUT=%h expected 1 %h", readySecond, VALID, DOUT, expDout);
    end
    assertCount++;
    if (OVERRUN !== !readySecond || ovrCycles.size() != (readySecond ? 0 : 1) || errCycles.size() != 0) begin
      failCount++;
      $display("[TB] FAIL b2b_overrun(ready=%b): OVERRUN=%b pulses=%0d errs=%0d expected %b %0d 0",
               readySecond, OVERRUN, ovrCycles.size(), errCycles.size(), !readySecond, readySecond ? 0 : 1);
    end
    @(negedge CLK);
    assertCount++;
    if (VALID !== 1'b1 || OVERRUN !== 1'b0 || DOUT !== expDout) begin
      failCount++;
      $display("[TB] FAIL b2b_hold(ready=%b): VALID=%b OVERRUN=%b DOUT=%h expected 1 0 %h",
               readySecond, VALID, OVERRUN, DOUT, expDout);
    end
  endtask

  task automatic test_reset_mid_frame();
    int s;
    assertCount++;
    if (VALID !== 1'b1 || DOUT !== 8'hC3) begin
      failCount++;
      $display("[TB] FAIL midrst_pre: VALID=%b DOUT=%h expected 1 c3", VALID, DOUT);
    end
    s = cyc;
    SIN = 1'b0;
    repeat (CPB) @(negedge CLK);
    while (cyc < s + 14) begin
      SIN = 1'($urandom_range(0, 1));
      @(negedge CLK);
    end
    assertCount++;
    if (BUSY !== 1'b1) begin
      failCount++;
      $display("[TB] FAIL midrst_busy: BUSY=%b expected 1", BUSY);
    end
    RST = 1'b0;
    SIN = 1'b1;
    #1;
    assertCount++;
    if ({VALID, BUSY, FRAME_ERR, OVERRUN, DOUT} !== '0) begin
      failCount++;
      $display("[TB] FAIL midrst_async: got %b expected all zero", {VALID, BUSY, FRAME_ERR, OVERRUN, DOUT});
    end
    repeat (3) @(negedge CLK);
    assertCount++;
    if ({VALID, BUSY, FRAME_ERR, OVERRUN, DOUT} !== '0) begin
      failCount++;
      $display("[TB] FAIL midrst_held: got %b expected all zero", {VALID, BUSY, FRAME_ERR, OVERRUN, DOUT});
    end
    RST = 1'b1;
    repeat (3) @(negedge CLK);
    READY = 1'b1;
    clear_logs();
    send_frame(8'h81, 1'b1, s);
    wait_to(s + LAT);
    assertCount++;
    if (VALID !== 1'b1 || DOUT !== 8'h81 || errCycles.size() != 0) begin
      failCount++;
      $display("[TB] FAIL midrst_next_frame: VALID=%b DOUT=%h errs=%0d expected 1 81 0", VALID, DOUT, errCycles.size());
    end
  endtask

`ifdef SERIAL_RX_PARITY_EN
  task automatic test_parity();
    int s;
    drain();
    READY = 1'b1;
    flipParity = 1'b1;
    send_frame(8'h81, 1'b1, s);
    flipParity = 1'b0;
    wait_to(s + LAT);
    assertCount++;
    if (FRAME_ERR !== 1'b1 || VALID !== 1'b0 || errCycles.size() != 1 || riseCycles.size() != 0) begin
      failCount++;
      $display("[TB] FAIL parity_error: FRAME_ERR=%b VALID=%b errs=%0d rises=%0d expected 1 0 1 0",
               FRAME_ERR, VALID, errCycles.size(), riseCycles.size());
    end
  endtask
`endif

  task automatic test_glitch();
    int busyCount;
    drain();
    busyCount = 0;
    SIN = 1'b0;
    @(negedge CLK);
    SIN = 1'b1;
    repeat (3 * CPB) begin
      @(negedge CLK);
      if (BUSY) busyCount++;
    end
    assertCount++;
    if (busyCount < 1 || busyCount > CPB / 2 + 1) begin
      failCount++;
      $display("[TB] FAIL glitch_busy: busy for %0d cycles, expected 1..%0d", busyCount, CPB / 2 + 1);
    end
    assertCount++;
    if (riseCycles.size() != 0 || errCycles.size() != 0 || BUSY !== 1'b0) begin
      failCount++;
      $display("[TB] FAIL glitch_no_event: rises=%0d errs=%0d BUSY=%b expected 0 0 0",
               riseCycles.size(), errCycles.size(), BUSY);
    end
  endtask

  task automatic test_frame_error();
    int s, s2, busyAfter;
    drain();
    READY = 1'b1;
    busyAfter = 0;
    send_frame(8'h55, 1'b0, s);
    wait_to(s + LAT);
    assertCount++;
    if (FRAME_ERR !== 1'b1 || VALID !== 1'b0) begin
      failCount++;
      $display("[TB] FAIL ferr_pulse: FRAME_ERR=%b VALID=%b expected 1 0", FRAME_ERR, VALID);
    end
    while (cyc < s + NBITS * CPB + 20) begin
      @(negedge CLK);
      if (BUSY) busyAfter++;
    end
    assertCount++;
    if (errCycles.size() != 1 || riseCycles.size() != 0 || busyAfter != 0) begin
      failCount++;
      $display("[TB] FAIL ferr_no_retrigger: errs=%0d rises=%0d busy cycles=%0d expected 1 0 0",
               errCycles.size(), riseCycles.size(), busyAfter);
    end
    SIN = 1'b1;
    repeat (4) @(negedge CLK);
    send_frame(8'h12, 1'b1, s2);
    wait_to(s2 + LAT);
    assertCount++;
    if (VALID !== 1'b1 || DOUT !== 8'h12) begin
      failCount++;
      $display("[TB] FAIL ferr_recover: VALID=%b DOUT=%h expected 1 12", VALID, DOUT);
    end
  endtask

  // Frame-level model: a word is kept if the register is empty or being consumed, else dropped
  task automatic test_random();
    int s, gap;
    logic [DATA_W-1:0] data, mDout;
    logic stopBit, rdy, mValid, expErr, expOvr;
    drain();
    mValid = 1'b0;
    mDout = '0;
    for (int n = 0; n < 12; n++) begin
      data = DATA_W'($urandom);
      stopBit = (n == 0) ? 1'b1 : ($urandom_range(0, 4) != 0);
      rdy = (n == 0) ? 1'b1 : 1'($urandom_range(0, 1));
      READY = rdy;
      gap = $urandom_range(1, 6);
      repeat (gap) @(negedge CLK);
      if (mValid && rdy) mValid = 1'b0;
      expErr = !stopBit;
      expOvr = stopBit && mValid;
      send_frame(data, stopBit, s);
      wait_to(s + LAT - 1);
      assertCount++;
      if (VALID !== mValid) begin
        failCount++;
        $display("[TB] FAIL rand_pre[%0d]: VALID=%b expected %b", n, VALID, mValid);
      end
      if (stopBit && !mValid) begin
        mValid = 1'b1;
        mDout = data;
      end
      wait_to(s + LAT);
      assertCount++;
      if (VALID !== mValid || DOUT !== mDout || FRAME_ERR !== expErr || OVERRUN !== expOvr) begin
        failCount++;
        $display("[TB] FAIL rand_frame[%0d]: VALID=%b DOUT=%h FRAME_ERR=%b OVERRUN=%b expected %b %h %b %b",
                 n, VALID, DOUT, FRAME_ERR, OVERRUN, mValid, mDout, expErr, expOvr);
      end
      SIN = 1'b1;
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back(1'b0);
    test_back_to_back(1'b1);
    test_reset_mid_frame();
`ifdef SERIAL_RX_PARITY_EN
    test_parity();
`endif
    test_glitch();
    test_frame_error();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
